// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and payload types for the systolic array
// result write-back path.
package systolic_pkg;

  localparam int unsigned N          = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OUT_AW     = 7;
  localparam int unsigned MAX_TILES  = 8;
  localparam int unsigned TILE_WORDS = N * N;
  localparam int unsigned IDX_W      = $clog2(TILE_WORDS);
  localparam int unsigned TILE_W     = $clog2(MAX_TILES);
  localparam int unsigned NT_W       = TILE_W + 1;
  localparam int unsigned ACC_W      = TILE_WORDS * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [OUT_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  // Programs longer than the output memory holds are cut to MAX_TILES.
  function automatic logic [NT_W-1:0] clamp_tiles(input logic [NT_W-1:0] n);
    return (n > NT_W'(MAX_TILES)) ? NT_W'(MAX_TILES) : n;
  endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Tile capture handshake from the PE grid plus the output memory write port.
interface result_writeback_if;
  import systolic_pkg::*;

  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;
  logic              mem_we;
  logic [OUT_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  acc_valid, acc_data,
    output acc_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output acc_valid, acc_data,
    input  acc_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/result_writeback_acc_snapshot.sv
// Snapshot bank holding one captured 4x4 accumulator tile, with a read mux
// so the grid can start its next instruction while the tile drains.
module acc_snapshot
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ACC_W-1:0]  i_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data_c
);

  logic [DATA_W-1:0] r_snap [TILE_WORDS];

  for (genvar g = 0; g < int'(TILE_WORDS); g++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_snap[g] <= '0;
      end else if (i_load) begin
        r_snap[g] <= i_data[g*DATA_W +: DATA_W];
      end
    end
  end

  assign o_rd_data_c = r_snap[i_rd_idx];

endmodule

// File: rtl/result_writeback.sv
// Captures each finished PE tile and serialises it, row-major, into the
// output memory at tile*16 + row*4 + col; flags completion of the program.
module result_writeback
  import systolic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [NT_W-1:0]     i_num_tiles,
  result_writeback_if.master  bus,
  output logic [TILE_W-1:0]   o_tile_idx,
  output logic                o_busy,
  output logic                o_done
);

  wb_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_k, w_k_nxt;
  logic [TILE_W-1:0] r_tile, w_tile_nxt;
  logic [NT_W-1:0]   r_tiles_lat, w_tiles_lat_nxt;
  logic              r_done, w_done_nxt;
  logic              r_we, w_we_nxt;
  mem_wr_t           r_wr, w_wr_nxt;
  logic              w_capture;
  logic              w_last_tile;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_snap_rd;

  // r_k is the index of the word currently on the memory port; read one ahead.
  assign w_rd_idx    = r_k + IDX_W'(1);
  assign w_last_tile = ({1'b0, r_tile} + NT_W'(1)) == r_tiles_lat;

  acc_snapshot u_snap (
    .clk         (clk),
    .rst_n       (rst),
    .i_load      (w_capture),
    .i_data      (bus.acc_data),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data_c (w_snap_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counters and the next memory write; start overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_tile_nxt      = r_tile;
    w_tiles_lat_nxt = r_tiles_lat;
    w_done_nxt      = r_done;
    w_we_nxt        = 1'b0;
    w_wr_nxt        = r_wr;
    w_capture       = 1'b0;

    if (i_start) begin
      w_tile_nxt      = '0;
      w_k_nxt         = '0;
      w_tiles_lat_nxt = clamp_tiles(i_num_tiles);
      if (i_num_tiles == '0) begin
        w_state_nxt = DONE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ARMED;
        w_done_nxt  = 1'b0;
      end
    end else begin
      case (r_state)
        ARMED: begin
          if (bus.acc_valid) begin
            // Word 0 goes straight from the grid so the first write lands next cycle.
            w_capture     = 1'b1;
            w_state_nxt   = DRAIN;
            w_k_nxt       = '0;
            w_we_nxt      = 1'b1;
            w_wr_nxt.addr = {r_tile, IDX_W'(0)};
            w_wr_nxt.data = bus.acc_data[DATA_W-1:0];
          end
        end
        DRAIN: begin
          if (r_k == IDX_W'(TILE_WORDS - 1)) begin
            if (w_last_tile) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ARMED;
              w_tile_nxt  = r_tile + TILE_W'(1);
            end
          end else begin
            w_k_nxt       = w_rd_idx;
            w_we_nxt      = 1'b1;
            w_wr_nxt.addr = {r_tile, w_rd_idx};
            w_wr_nxt.data = w_snap_rd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k         <= '0;
      r_tile      <= '0;
      r_tiles_lat <= '0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_wr        <= '0;
    end else begin
      r_k         <= w_k_nxt;
      r_tile      <= w_tile_nxt;
      r_tiles_lat <= w_tiles_lat_nxt;
      r_done      <= w_done_nxt;
      r_we        <= w_we_nxt;
      r_wr        <= w_wr_nxt;
    end
  end

  assign bus.acc_ready = (r_state == ARMED);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_wr.addr;
  assign bus.mem_wdata = r_wr.data;

  assign o_tile_idx = r_tile;
  assign o_busy     = (r_state == ARMED) || (r_state == DRAIN);
  assign o_done     = r_done;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: captures, drain order, completion,
// clamping, abort-by-start and asynchronous reset.
module tb_result_writeback;
  import systolic_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_tiles = '0;
  logic [2:0]  tile_idx;
  logic        busy;
  logic        done;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  logic [6:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int unsigned cap_cyc [$];
  int unsigned rdy_in_drain = 0;

  result_writeback_if bus ();

  result_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_num_tiles (num_tiles),
    .bus         (bus),
    .o_tile_idx  (tile_idx),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side observer: records writes and handshakes mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus.acc_ready === 1'b1 && bus.mem_we === 1'b1) rdy_in_drain++;
    if (bus.acc_valid === 1'b1 && bus.acc_ready === 1'b1 && start === 1'b0) cap_cyc.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    cap_cyc.delete();
    rdy_in_drain = 0;
  endtask

  task automatic set_tile(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 16; i++) bus.acc_data[i*32 +: 32] = base + step * 32'(i);
  endtask

  task automatic pulse_start(input logic [3:0] n);
    num_tiles = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.acc_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    repeat (3) tick();
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("FAIL reset_acc_ready got=%b exp=0", bus.acc_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tile_idx !== 3'd0) begin errors++; $display("FAIL reset_tile_idx got=%0d exp=0", tile_idx); end
    rst = 1'b1;
    tick();
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("FAIL idle_acc_ready got=%b exp=0", bus.acc_ready); end
  endtask

  task automatic test_single();
    bit ok;
    int unsigned c_last;
    int unsigned c_done;
    clear_log();
    set_tile(32'hFFFF_FFFF, 32'd1);
    pulse_start(4'd1);
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL single_armed got=%b exp=1", bus.acc_ready); end
    bus.acc_valid = 1'b1;
    tick();
    bus.acc_valid = 1'b0;
    ok = 1'b0; c_last = 0; c_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_we === 1'b1 && bus.mem_addr === 7'd15) c_last = cyc;
      if (done === 1'b1) begin
        ok = 1'b1;
        c_done = cyc;
        break;
      end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got=0 exp=1"); end
    checks++; if (c_done !== c_last + 1) begin errors++; $display("FAIL single_done_latency got=%0d exp=%0d", c_done, c_last + 1); end
    checks++; if (wr_addr.size() !== 16) begin errors++; $display("FAIL single_write_count got=%0d exp=16", wr_addr.size()); end
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== 7'(i)) begin errors++; $display("FAIL single_addr[%0d] got=%0d exp=%0d", i, wr_addr[i], i); end
      checks++; if (wr_data[i] !== 32'(i - 1)) begin errors++; $display("FAIL single_data[%0d] got=%0h exp=%0h", i, wr_data[i], 32'(i - 1)); end
    end
    checks++; if (tile_idx !== 3'd0) begin errors++; $display("FAIL single_tile_idx got=%0d exp=0", tile_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy); end
  endtask

  task automatic test_multi();
    bit ok;
    clear_log();
    set_tile(32'd14, 32'd0);
    pulse_start(4'd5);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multi_done_cleared got=%b exp=0", done); end
    for (int t = 0; t < 5; t++) begin
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL multi_ready_timeout tile=%0d got=0 exp=1", t); end
      checks++; if (tile_idx !== 3'(t)) begin errors++; $display("FAIL multi_tile_idx got=%0d exp=%0d", tile_idx, t); end
      repeat (3) tick();
      bus.acc_valid = 1'b1;
      tick();
      bus.acc_valid = 1'b0;
    end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_done_timeout got=0 exp=1"); end
    checks++; if (wr_addr.size() !== 80) begin errors++; $display("FAIL multi_write_count got=%0d exp=80", wr_addr.size()); end
    for (int i = 0; i < 80 && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== 7'(i)) begin errors++; $display("FAIL multi_addr[%0d] got=%0d exp=%0d", i, wr_addr[i], i); end
      checks++; if (wr_data[i] !== 32'd14) begin errors++; $display("FAIL multi_data[%0d] got=%0h exp=e", i, wr_data[i]); end
    end
    checks++; if (rdy_in_drain !== 0) begin errors++; $display("FAIL multi_ready_in_drain got=%0d exp=0", rdy_in_drain); end
    checks++; if (tile_idx !== 3'd4) begin errors++; $display("FAIL multi_final_tile got=%0d exp=4", tile_idx); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    set_tile(32'd100, 32'd1);
    bus.acc_valid = 1'b1;
    pulse_start(4'd2);
    wait_done(ok);
    bus.acc_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout got=0 exp=1"); end
    checks++; if (wr_addr.size() !== 32) begin errors++; $display("FAIL b2b_write_count got=%0d exp=32", wr_addr.size()); end
    for (int i = 0; i < 32 && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== 7'(i)) begin errors++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, wr_addr[i], i); end
      checks++; if (wr_data[i] !== 32'(100 + (i % 16))) begin errors++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, wr_data[i], 100 + (i % 16)); end
    end
    checks++; if (cap_cyc.size() !== 2) begin errors++; $display("FAIL b2b_capture_count got=%0d exp=2", cap_cyc.size()); end
    if (cap_cyc.size() >= 2) begin
      checks++; if (cap_cyc[1] - cap_cyc[0] !== 17) begin errors++; $display("FAIL b2b_capture_gap got=%0d exp=17", cap_cyc[1] - cap_cyc[0]); end
    end
    checks++; if (tile_idx !== 3'd1) begin errors++; $display("FAIL b2b_tile_idx got=%0d exp=1", tile_idx); end
  endtask

  task automatic test_zero_and_clamp();
    bit ok;
    clear_log();
    pulse_start(4'd1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_pre_done got=%b exp=0", done); end
    pulse_start(4'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy); end
    repeat (5) tick();
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL zero_writes got=%0d exp=0", wr_addr.size()); end

    clear_log();
    pulse_start(4'd12);
    for (int t = 0; t < 8; t++) begin
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL clamp_ready_timeout tile=%0d got=0 exp=1", t); end
      set_tile(32'(t * 16), 32'd1);
      bus.acc_valid = 1'b1;
      tick();
      bus.acc_valid = 1'b0;
    end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_done_timeout got=0 exp=1"); end
    checks++; if (wr_addr.size() !== 128) begin errors++; $display("FAIL clamp_write_count got=%0d exp=128", wr_addr.size()); end
    for (int i = 0; i < 128 && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== 7'(i) || wr_data[i] !== 32'(i)) begin errors++; $display("FAIL clamp_word[%0d] got=%0d/%0d exp=%0d/%0d", i, wr_addr[i], wr_data[i], i, i); end
    end
    checks++; if (tile_idx !== 3'd7) begin errors++; $display("FAIL clamp_tile_idx got=%0d exp=7", tile_idx); end
    checks++; if (cap_cyc.size() !== 8) begin errors++; $display("FAIL clamp_captures got=%0d exp=8", cap_cyc.size()); end
  endtask

  task automatic test_abort();
    bit ok;
    clear_log();
    set_tile(32'h8000_0000, 32'd1);
    pulse_start(4'd2);
    bus.acc_valid = 1'b1;
    tick();
    bus.acc_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_we === 1'b1 && bus.mem_addr === 7'd6) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL abort_addr6_timeout got=0 exp=1"); end
    pulse_start(4'd2);
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL abort_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL abort_armed got=%b exp=1", bus.acc_ready); end
    checks++; if (tile_idx !== 3'd0) begin errors++; $display("FAIL abort_tile_idx got=%0d exp=0", tile_idx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got=%b exp=1", busy); end
    checks++; if (wr_addr.size() !== 7) begin errors++; $display("FAIL abort_partial_count got=%0d exp=7", wr_addr.size()); end
    for (int i = 0; i < 7 && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== 7'(i) || wr_data[i] !== 32'h8000_0000 + 32'(i)) begin errors++; $display("FAIL abort_partial[%0d] got=%0d/%0h exp=%0d/%0h", i, wr_addr[i], wr_data[i], i, 32'h8000_0000 + 32'(i)); end
    end

    clear_log();
    set_tile(32'd200, 32'd1);
    bus.acc_valid = 1'b1;
    tick();
    bus.acc_valid = 1'b0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_rearm_timeout got=0 exp=1"); end
    checks++; if (tile_idx !== 3'd1) begin errors++; $display("FAIL abort_next_tile got=%0d exp=1", tile_idx); end
    checks++; if (wr_addr.size() !== 16) begin errors++; $display("FAIL abort_rewrite_count got=%0d exp=16", wr_addr.size()); end
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== 7'(i) || wr_data[i] !== 32'(200 + i)) begin errors++; $display("FAIL abort_rewrite[%0d] got=%0d/%0d exp=%0d/%0d", i, wr_addr[i], wr_data[i], i, 200 + i); end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    pulse_start(4'd1);
    clear_log();
    set_tile(32'd300, 32'd1);
    bus.acc_valid = 1'b1;
    tick();
    bus.acc_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_we === 1'b1 && bus.mem_addr === 7'd9) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_addr9_timeout got=0 exp=1"); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("FAIL rstmid_acc_ready got=%b exp=0", bus.acc_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (2) tick();
    rst = 1'b1;
    cap_cyc.delete();
    bus.acc_valid = 1'b1;
    repeat (5) tick();
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("FAIL rstmid_idle_ready got=%b exp=0", bus.acc_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy got=%b exp=0", busy); end
    checks++; if (cap_cyc.size() !== 0) begin errors++; $display("FAIL rstmid_idle_capture got=%0d exp=0", cap_cyc.size()); end
    checks++; if (wr_addr.size() !== 9) begin errors++; $display("FAIL rstmid_write_count got=%0d exp=9", wr_addr.size()); end
    bus.acc_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_zero_and_clamp();
    test_abort();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
